// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO sequencing controller: FSM states,
// last-served encoding and default sizing.
package fifo_pkg;

  localparam int W_DEFAULT = 2;
  localparam int DEPTH     = 2 ** W_DEFAULT;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    RD   = 2'd2,
    GAP  = 2'd3
  } state_t;

  typedef enum logic {
    SERVED_READ  = 1'b0,
    SERVED_WRITE = 1'b1
  } served_t;

endpackage

// File: rtl/fifo_ptr.sv
// W-bit wrapping pointer with increment enable; wraps naturally modulo 2**W.
module fifo_ptr #(
  parameter int W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] ptr
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_ctrl.sv
// Sequencing controller for an edge-triggered FIFO register file: arbitrates
// write/read requests into isolated strobes and tracks occupancy.
// Optional sticky ovf/udf flags are built when FIFO_CTRL_ERR_FLAG_EN is defined.
module fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         wr_req,
  input  logic         rd_req,
  input  logic         err_clr,
  output logic         wr_ack,
  output logic         rd_valid,
  output logic         wr_en,
  output logic         re_en,
  output logic [W-1:0] w_addr,
  output logic [W-1:0] r_addr,
  output logic         full,
  output logic         empty,
  output logic [W:0]   count,
  output logic         busy,
  output logic         ovf,
  output logic         udf
);

  localparam logic [W:0] FULL_COUNT = {1'b1, {W{1'b0}}};

  state_t     state, next_state;
  served_t    last_served, next_served;
  logic       wr_elig, rd_elig;
  logic       w_inc, r_inc;
  logic [W:0] next_count;

  // Round-robin between eligible requests; pointer/count commit on GAP exit.
  always_comb begin
    wr_elig     = wr_req & ~full;
    rd_elig     = rd_req & ~empty;
    next_state  = state;
    next_served = last_served;
    w_inc       = 1'b0;
    r_inc       = 1'b0;
    next_count  = count;
    case (state)
      IDLE: begin
        if (wr_elig && (!rd_elig || last_served == SERVED_READ)) begin
          next_state  = WR;
          next_served = SERVED_WRITE;
        end else if (rd_elig) begin
          next_state  = RD;
          next_served = SERVED_READ;
        end
      end
      WR, RD: next_state = GAP;
      GAP: begin
        next_state = IDLE;
        if (last_served == SERVED_WRITE) begin
          w_inc      = 1'b1;
          next_count = count + 1'b1;
        end else begin
          r_inc      = 1'b1;
          next_count = count - 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Outputs are decoded from next_state so each is a flop, not state decode.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_served <= SERVED_READ;
      wr_en       <= 1'b0;
      re_en       <= 1'b0;
      wr_ack      <= 1'b0;
      rd_valid    <= 1'b0;
      busy        <= 1'b0;
      count       <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
    end else begin
      state       <= next_state;
      last_served <= next_served;
      wr_en       <= (next_state == WR);
      re_en       <= (next_state == RD);
      wr_ack      <= (state == WR);
      rd_valid    <= (state == RD);
      busy        <= (next_state != IDLE);
      count       <= next_count;
      full        <= (next_count == FULL_COUNT);
      empty       <= (next_count == '0);
    end
  end

  fifo_ptr #(.W(W)) u_wptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_inc),
    .ptr   (w_addr)
  );

  fifo_ptr #(.W(W)) u_rptr (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (r_inc),
    .ptr   (r_addr)
  );

`ifdef FIFO_CTRL_ERR_FLAG_EN
  // Sticky error flags; a clear wins over a set in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else if (err_clr) begin
      ovf <= 1'b0;
      udf <= 1'b0;
    end else begin
      if (state == IDLE && wr_req && full) ovf <= 1'b1;
      if (state == IDLE && rd_req && empty) udf <= 1'b1;
    end
  end
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign ovf = 1'b0;
  assign udf = 1'b0;
`endif

endmodule
